intpol2_window_feeder: RTL and testbench
========================================

INTPOL2_WINDOW_FEEDER -- requirements
Module: intpol2_window_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the sample width in bits (Q2.30 two's-complement, passed through unmodified).
REQ-002 The block SHALL have parameter MEM_SIZE_M, default 2, giving the window address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: permits window filling and core starts.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous abort that returns to IDLE and discards the window.
REQ-007 The block SHALL have port s_data, input, DATA_WIDTH bits: upstream sample.
REQ-008 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-009 The block SHALL have port s_ready, output, 1 bit: the block accepts s_data this cycle.
REQ-010 The block SHALL have port M_addr_i, input, MEM_SIZE_M bits: window read address driven by the interpolator core.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits: registered window read data to the core.
REQ-012 The block SHALL have port start_o, output, 1 bit: one-cycle start pulse to the core.
REQ-013 The block SHALL have port done_i, input, 1 bit: the core's done status bit (status_reg[0]).
REQ-014 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port frame_cnt, output, 16 bits: number of start pulses issued.

Function
REQ-016 The window storage SHALL be 3 entries, m0 at address 0, m1 at address 1 and m2 at address 2.
REQ-017 data_out SHALL be driven as mem[M_addr_i] registered, with exactly 1-cycle read latency on every cycle, regardless of state.
REQ-018 A read of address 3 (or any address of 3 or above) SHALL return 0.
REQ-019 A read of an entry being written in the same cycle SHALL return the old value.
REQ-020 The FSM SHALL have the states IDLE, FILL, START, WAIT and SHIFT.
REQ-021 IDLE: when enable=1, the FSM SHALL go to FILL with wr_ptr=0 and need=3.
REQ-022 FILL: s_ready SHALL be 1.
REQ-023 FILL: on s_valid&&s_ready the block SHALL write mem[wr_ptr]<=s_data, increment wr_ptr and decrement need.
REQ-024 FILL: when the accepted sample brings need to 0, the next state SHALL be START.
REQ-025 FILL: enable=0 SHALL NOT stall or exit FILL; only flush exits FILL.
REQ-026 s_ready SHALL be 0 in every state other than FILL.
REQ-027 START: start_o SHALL be 1 for exactly one cycle, frame_cnt SHALL increment (wrapping at 16 bits, 0xFFFF->0x0000), and the next state SHALL be WAIT.
REQ-028 WAIT: the FSM SHALL hold until done_i=1, then go to SHIFT; done_i SHALL be ignored in all other states.
REQ-029 SHIFT (1 cycle): mem[0]<=mem[2] (the last sample becomes the new m0, so segments overlap by one sample).
REQ-030 SHIFT: if enable=1 the next state SHALL be FILL with wr_ptr=1 and need=2; otherwise the next state SHALL be IDLE and the next fill SHALL need 3.
REQ-031 Minimum latency from the 3rd accepted sample to start_o SHALL be 1 cycle (start_o on the cycle after acceptance).
REQ-032 Minimum latency from done_i to s_ready=1 SHALL be 2 cycles.
REQ-033 flush=1 in any state SHALL force IDLE next cycle, clear wr_ptr and need, and suppress start_o; memory contents SHALL be retained but treated as invalid (the next fill needs 3).
REQ-034 flush has priority over all transitions; rst has priority over flush.
REQ-035 flush in the same cycle as a sample handshake SHALL discard that sample.
REQ-036 done_i arriving on the same cycle as start_o SHALL be ignored.

Reset
REQ-037 When rst=1 on a rising edge, the block SHALL enter IDLE with s_ready=0, start_o=0, busy_o=0, frame_cnt=0, data_out=0, wr_ptr=0 and need=3.
REQ-038 Window memory contents SHALL NOT be cleared by reset.
REQ-039 Reset mid-WAIT SHALL NOT produce start_o and SHALL restart a 3-sample fill.

Verification
REQ-040 Scenario — basic fill: enable=1, stream 0x278DDE6E, 0x4B3C8C12, 0x678DDE6E with s_valid held -> three handshakes, start_o high one cycle after the third handshake, frame_cnt=1; reads of addresses 0/1/2 return the three values one cycle later, and address 3 returns 0.
REQ-041 Scenario — overlap: after the basic fill, pulse done_i, then stream 0x11111111, 0x22222222 -> mem = {0x678DDE6E, 0x11111111, 0x22222222}, a second start_o is issued, and frame_cnt=2.
REQ-042 Scenario — backpressure: toggle s_valid randomly 50% -> exactly 3 (first) then 2 (subsequent) samples are accepted per frame, no sample is lost or duplicated, and s_ready=0 throughout START, WAIT and SHIFT.
REQ-043 Scenario — stray done: done_i pulsed during FILL and IDLE -> no state change and no start_o.
REQ-044 Scenario — flush mid-FILL after 2 samples with s_valid=1 -> the sample in the flush cycle is dropped, IDLE is entered, and the next frame requires 3 samples.
REQ-045 Scenario — rst asserted in WAIT and enable low at SHIFT: rst -> all outputs return to reset values and frame_cnt=0; enable=0 when done_i arrives -> IDLE after SHIFT, busy_o=0, and the next frame requires 3 samples.

Source files
------------

// File: rtl/intpol2_window_feeder.sv
// Feeds a 3-sample sliding window to a 2-point interpolator core.
// Consecutive windows overlap by one sample: the last sample of a frame becomes m0 of the next.
module intpol2_window_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_SIZE_M = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [MEM_SIZE_M-1:0] M_addr_i,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  start_o,
   input  logic                  done_i,
   output logic                  busy_o,
   output logic [15:0]           frame_cnt
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FILL  = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] SHIFT = 3'd4;

   logic [2:0]            state;
   logic [1:0]            wr_ptr;
   logic [1:0]            need;
   logic [DATA_WIDTH-1:0] mem [0:2];
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  handshake;

   assign s_ready   = (state == FILL);
   assign handshake = s_valid && s_ready;
   assign busy_o    = (state != IDLE);
   // A flush arriving while in START cancels the pulse and the frame count.
   assign start_o   = (state == START) && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= 2'd0;
         need      <= 2'd3;
         frame_cnt <= 16'd0;
      end else if (flush) begin
         state  <= IDLE;
         wr_ptr <= 2'd0;
         need   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state  <= FILL;
                  wr_ptr <= 2'd0;
                  need   <= 2'd3;
               end
            end
            FILL: begin
               if (handshake) begin
                  wr_ptr <= wr_ptr + 2'd1;
                  need   <= need - 2'd1;
                  if (need == 2'd1) begin
                     state <= START;
                  end
               end
            end
            START: begin
               frame_cnt <= frame_cnt + 16'd1;
               state     <= WAIT;
            end
            WAIT: begin
               if (done_i) begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (enable) begin
                  state  <= FILL;
                  wr_ptr <= 2'd1;
                  need   <= 2'd2;
               end else begin
                  state  <= IDLE;
                  wr_ptr <= 2'd0;
                  need   <= 2'd3;
               end
            end
            default: begin
               state  <= IDLE;
               wr_ptr <= 2'd0;
               need   <= 2'd3;
            end
         endcase
      end
   end

   // Window storage is deliberately not reset; a flush or reset only invalidates it.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (handshake && (wr_ptr != 2'd3)) begin
            mem[wr_ptr] <= s_data;
         end else if (state == SHIFT) begin
            mem[0] <= mem[2];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 3; i++) begin
         if (32'(M_addr_i) == 32'(i)) begin
            rd_data = mem[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
      end else begin
         data_out <= rd_data;
      end
   end

endmodule

// File: tb/tb_intpol2_window_feeder.sv
// Directed self-checking bench for intpol2_window_feeder.
module tb_intpol2_window_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        flush;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [1:0]  M_addr_i;
   logic [31:0] data_out;
   logic        start_o;
   logic        done_i;
   logic        busy_o;
   logic [15:0] frame_cnt;

   int assert_count = 0;
   int fail_count   = 0;

   intpol2_window_feeder #(.DATA_WIDTH(32), .MEM_SIZE_M(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .M_addr_i(M_addr_i), .data_out(data_out), .start_o(start_o),
      .done_i(done_i), .busy_o(busy_o), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] expected);
      M_addr_i = addr;
      step();
      check_output(tag, data_out, expected);
   endtask

   task automatic push(input logic [31:0] value);
      s_valid = 1'b1;
      s_data  = value;
      step();
   endtask

   logic [31:0] bp_vals [3];
   logic        bp_pat  [7];
   int          acc;

   initial begin
      rst = 1'b1; enable = 1'b0; flush = 1'b0; s_data = '0; s_valid = 1'b0;
      M_addr_i = 2'd0; done_i = 1'b0;
      step(); step();
      check_output("rst_s_ready", 32'(s_ready), 32'd0);
      check_output("rst_start", 32'(start_o), 32'd0);
      check_output("rst_busy", 32'(busy_o), 32'd0);
      check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_output("rst_data_out", data_out, 32'd0);
      rst = 1'b0;

      // Basic fill
      enable = 1'b1;
      step();
      check_output("fill_ready", 32'(s_ready), 32'd1);
      check_output("fill_busy", 32'(busy_o), 32'd1);
      push(32'h278DDE6E);
      push(32'h4B3C8C12);
      check_output("fill_no_early_start", 32'(start_o), 32'd0);
      push(32'h678DDE6E);
      s_valid = 1'b0;
      check_output("basic_start", 32'(start_o), 32'd1);
      check_output("start_not_ready", 32'(s_ready), 32'd0);
      step();
      check_output("wait_start_low", 32'(start_o), 32'd0);
      check_output("basic_frame_cnt", 32'(frame_cnt), 32'd1);
      check_output("wait_not_ready", 32'(s_ready), 32'd0);
      read_check("basic_m0", 2'd0, 32'h278DDE6E);
      read_check("basic_m1", 2'd1, 32'h4B3C8C12);
      read_check("basic_m2", 2'd2, 32'h678DDE6E);
      read_check("basic_addr3", 2'd3, 32'd0);

      // Overlap frame; done_i during START must be ignored
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      check_output("shift_not_ready", 32'(s_ready), 32'd0);
      check_output("shift_busy", 32'(busy_o), 32'd1);
      step();
      check_output("done_to_ready", 32'(s_ready), 32'd1);
      push(32'h11111111);
      push(32'h22222222);
      s_valid = 1'b0;
      check_output("overlap_start", 32'(start_o), 32'd1);
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      check_output("overlap_frame_cnt", 32'(frame_cnt), 32'd2);
      step();
      check_output("done_at_start_ignored", 32'(s_ready), 32'd0);
      check_output("still_waiting", 32'(busy_o), 32'd1);
      read_check("overlap_m0", 2'd0, 32'h678DDE6E);
      read_check("overlap_m1", 2'd1, 32'h11111111);
      read_check("overlap_m2", 2'd2, 32'h22222222);

      // enable low at SHIFT returns to IDLE; stray done in IDLE does nothing
      enable = 1'b0;
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      step();
      check_output("idle_after_shift", 32'(busy_o), 32'd0);
      check_output("idle_not_ready", 32'(s_ready), 32'd0);
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      check_output("idle_stray_busy", 32'(busy_o), 32'd0);
      check_output("idle_stray_start", 32'(start_o), 32'd0);

      // Backpressured 3-sample fill with enable dropped and stray done mid-FILL
      enable = 1'b1;
      step();
      enable = 1'b0;
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      check_output("fill_stray_ready", 32'(s_ready), 32'd1);
      check_output("fill_stray_start", 32'(start_o), 32'd0);
      bp_vals = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
      bp_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      acc = 0;
      for (int i = 0; i < 7 && acc < 3; i++) begin
         s_valid = bp_pat[i];
         s_data  = bp_pat[i] ? bp_vals[acc] : 32'hDEADBEEF;
         check_output("bp_ready", 32'(s_ready), 32'd1);
         step();
         if (bp_pat[i]) acc++;
      end
      s_valid = 1'b0;
      check_output("bp_start", 32'(start_o), 32'd1);
      step();
      check_output("bp_frame_cnt", 32'(frame_cnt), 32'd3);
      read_check("bp_m0", 2'd0, 32'hA0000001);
      read_check("bp_m1", 2'd1, 32'hB0000002);
      read_check("bp_m2", 2'd2, 32'hC0000003);

      // Reset in WAIT
      rst = 1'b1;
      step();
      check_output("wrst_start", 32'(start_o), 32'd0);
      check_output("wrst_busy", 32'(busy_o), 32'd0);
      check_output("wrst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_output("wrst_data_out", data_out, 32'd0);
      check_output("wrst_ready", 32'(s_ready), 32'd0);
      rst = 1'b0;
      read_check("mem_kept_on_rst", 2'd2, 32'hC0000003);

      // Flush mid-FILL after 2 samples drops the third
      enable = 1'b1;
      step();
      push(32'h0000000A);
      push(32'h0000000B);
      flush = 1'b1;
      push(32'h0000000C);
      flush = 1'b0;
      s_valid = 1'b0;
      check_output("flush_idle", 32'(busy_o), 32'd0);
      check_output("flush_no_start", 32'(start_o), 32'd0);
      read_check("flush_m0", 2'd0, 32'h0000000A);
      read_check("flush_m1", 2'd1, 32'h0000000B);
      read_check("flush_dropped", 2'd2, 32'hC0000003);
      push(32'h0000000D);
      push(32'h0000000E);
      check_output("refill_needs3_start", 32'(start_o), 32'd0);
      check_output("refill_needs3_ready", 32'(s_ready), 32'd1);
      push(32'h0000000F);
      s_valid = 1'b0;
      check_output("refill_start", 32'(start_o), 32'd1);
      step();
      check_output("refill_frame_cnt", 32'(frame_cnt), 32'd1);
      read_check("refill_m0", 2'd0, 32'h0000000D);
      read_check("refill_m1", 2'd1, 32'h0000000E);
      read_check("refill_m2", 2'd2, 32'h0000000F);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
